// File: rtl/uart_bus_sequencer_if.sv
// rtl/uart_bus_sequencer_if.sv - UART register-port bus between sequencer (master) and UART (slave)
interface uart_bus_sequencer_if;
  logic [15:0] a;
  logic        select;
  logic        r_w_n;
  logic [7:0]  d_out;
  logic [7:0]  d_in;
  logic        bus_access_strobe;

  modport master (
    output a, select, r_w_n, d_out,
    input  d_in, bus_access_strobe
  );

  modport slave (
    input  a, select, r_w_n, d_out,
    output d_in, bus_access_strobe
  );
endinterface

// File: rtl/uart_bus_sequencer.sv
// rtl/uart_bus_sequencer.sv - round-robin UART bus master: status polling, TX arbitration, RX drain
// Optional TX-busy timeout that drops a stuck request: `define UART_SEQ_TIMEOUT_EN
module uart_bus_sequencer #(
  parameter int          NUM_REQ        = 2,
  parameter logic [15:0] BASE_ADDR      = 16'hDF00,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic                   o_rx_valid,
  output logic [7:0]             o_rx_data,
  input  logic                   i_rx_ready,
  output logic                   o_timeout_err,
  uart_bus_sequencer_if.master   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ST_RD  = 3'd1,
    ST_CAP = 3'd2,
    RX_RD  = 3'd3,
    RX_CAP = 3'd4,
    TX_WR  = 3'd5
  } state_t;

  state_t             r_state, w_next;
  logic [PTR_W-1:0]   r_rr, r_grant, w_grant;
  logic [PTR_W:0]     w_sum;
  logic [7:0]         r_tx_byte, w_tx_pick;
  logic [NUM_REQ-1:0] r_req_ack;
  logic               r_rx_valid;
  logic [7:0]         r_rx_data;
  logic               w_done, w_any_req, w_take_rx, w_take_tx, w_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // d_in carries the status byte during ST_CAP: bit4 = TX idle, bit3 = receiver full
  assign w_done    = bus.select && bus.bus_access_strobe;
  assign w_any_req = |i_req_valid;
  assign w_take_rx = bus.d_in[3] && !r_rx_valid;
  assign w_take_tx = !w_take_rx && w_any_req && bus.d_in[4];

  always_comb begin
    w_grant   = r_rr;
    w_sum     = '0;
    w_tx_pick = 8'h00;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      if (i_req_valid[w_sum[PTR_W-1:0]]) w_grant = w_sum[PTR_W-1:0];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == PTR_W'(k)) w_tx_pick = i_req_data[8*k +: 8];
    end
  end

`ifdef UART_SEQ_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_to_err;
  logic        w_tx_blocked;

  assign w_tx_blocked = (r_state == ST_CAP) && !w_take_rx && w_any_req && !bus.d_in[4];
  assign w_drop       = w_tx_blocked && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_any_req || w_drop || (r_state == TX_WR && w_done)) r_to_cnt <= '0;
    else if (w_tx_blocked) r_to_cnt <= r_to_cnt + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_to_err <= 1'b0;
    else         r_to_err <= w_drop;
  end

  assign o_timeout_err = r_to_err;
`else
  assign w_drop        = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req || !r_rx_valid) w_next = ST_RD;
      ST_RD:   if (w_done) w_next = ST_CAP;
      ST_CAP: begin
        if (w_take_rx)      w_next = RX_RD;
        else if (w_take_tx) w_next = TX_WR;
        else                w_next = IDLE;
      end
      RX_RD:   if (w_done) w_next = RX_CAP;
      RX_CAP:  w_next = IDLE;
      TX_WR:   if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs decode from registered state and latched byte, so they hold until the strobe edge
  always_comb begin
    bus.select = 1'b0;
    bus.r_w_n  = 1'b1;
    bus.a      = BASE_ADDR;
    bus.d_out  = 8'h00;
    case (r_state)
      ST_RD: begin
        bus.select = 1'b1;
        bus.a      = BASE_ADDR + 16'd1;
      end
      RX_RD:  bus.select = 1'b1;
      TX_WR: begin
        bus.select = 1'b1;
        bus.r_w_n  = 1'b0;
        bus.d_out  = r_tx_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr       <= '0;
      r_grant    <= '0;
      r_tx_byte  <= 8'h00;
      r_req_ack  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else begin
      r_req_ack <= '0;
      if (r_state == ST_CAP && w_take_tx) begin
        r_grant   <= w_grant;
        r_tx_byte <= w_tx_pick;
      end
      if (r_state == TX_WR && w_done) begin
        r_req_ack <= NUM_REQ'(1) << r_grant;
        r_rr      <= ptr_inc(r_grant);
      end
      if (w_drop) begin
        r_req_ack <= NUM_REQ'(1) << w_grant;
        r_rr      <= ptr_inc(w_grant);
      end
      if (r_state == RX_CAP) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= bus.d_in;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_req_ack  = r_req_ack;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
endmodule

// File: tb/tb_uart_bus_sequencer.sv
// tb/tb_uart_bus_sequencer.sv - directed loopback bench for uart_bus_sequencer
module tb_uart_bus_sequencer;
  localparam logic [15:0] DATA_ADDR = 16'hDF00;
  localparam logic [15:0] STAT_ADDR = 16'hDF01;
  localparam int          TX_TIME   = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ack;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b1;
  logic        timeout_err;

  uart_bus_sequencer_if u_bus();

  uart_bus_sequencer #(
    .NUM_REQ(2),
    .BASE_ADDR(16'hDF00),
    .TIMEOUT_CYCLES(65535)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .o_req_ack(req_ack),
    .o_rx_valid(rx_valid),
    .o_rx_data(rx_data),
    .i_rx_ready(rx_ready),
    .o_timeout_err(timeout_err),
    .bus(u_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model with TX->RX loopback; a written byte appears in the receive queue TX_TIME clocks later
  logic [7:0] rx_q[$];
  logic [7:0] wr_log[$];
  logic [7:0] tx_byte = 8'h00;
  int         tx_cnt = 0;
  int         bad_wr = 0;
  int         bad_addr = 0;
  int         strobe_mode = 0;
  int         strobe_cyc = 0;

  always @(posedge clk) begin
    #1;
    strobe_cyc++;
    u_bus.bus_access_strobe = (strobe_mode == 0) || (strobe_cyc % 4 == 0);
  end

  always @(posedge clk) begin
    if (reset) begin
      rx_q.delete();
      tx_cnt = 0;
      u_bus.d_in <= 8'h00;
    end else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) rx_q.push_back(tx_byte);
      end
      if (u_bus.select && u_bus.bus_access_strobe) begin
        if (!u_bus.r_w_n) begin
          if (u_bus.a != DATA_ADDR) bad_addr++;
          else begin
            if (tx_cnt != 0) bad_wr++;
            wr_log.push_back(u_bus.d_out);
            tx_byte = u_bus.d_out;
            tx_cnt  = TX_TIME;
          end
        end else if (u_bus.a == STAT_ADDR) begin
          u_bus.d_in <= {3'b000, tx_cnt == 0, rx_q.size() != 0, 3'b000};
        end else if (u_bus.a == DATA_ADDR) begin
          if (rx_q.size() == 0) bad_addr++;
          else u_bus.d_in <= rx_q.pop_front();
        end else begin
          bad_addr++;
        end
      end
    end
  end

  logic [1:0]  ack_log[$];
  logic [7:0]  rx_got[$];
  int          stab_viol = 0;
  int          to_pulses = 0;
  int          rx_rd_held = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_a = 16'h0;
  logic        prev_rw = 1'b1;
  logic [7:0]  prev_dout = 8'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (req_ack != 2'b00) ack_log.push_back(req_ack);
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      if (timeout_err) to_pulses++;
      if (rx_valid && u_bus.select && u_bus.r_w_n && u_bus.a == DATA_ADDR) rx_rd_held++;
      if (prev_hold && (!u_bus.select || u_bus.a != prev_a || u_bus.r_w_n != prev_rw ||
                        u_bus.d_out != prev_dout)) stab_viol++;
    end
    prev_hold = u_bus.select && !u_bus.bus_access_strobe && !reset;
    prev_a    = u_bus.a;
    prev_rw   = u_bus.r_w_n;
    prev_dout = u_bus.d_out;
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    wr_log.delete();
    ack_log.delete();
    rx_got.delete();
  endtask

  task automatic send(input logic [1:0] mask, input logic [7:0] d0, input logic [7:0] d1,
                      input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_data  = {d1, d0};
    req_valid = mask;
    while (req_valid != 2'b00 && n < 2000) begin
      @(negedge clk);
      n++;
      req_valid = req_valid & ~req_ack;
    end
    check_eq({tag, "_all_acked"}, 32'(req_valid), 32'h0);
    req_valid = 2'b00;
  endtask

  task automatic wait_rx(input int cnt, input string tag);
    int n;
    n = 0;
    while (rx_got.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rx_count"}, 32'(rx_got.size()), 32'(cnt));
  endtask

  initial begin
    int  n;
    logic found;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_select", 32'(u_bus.select), 32'h0);
    check_eq("rst_r_w_n", 32'(u_bus.r_w_n), 32'h1);
    check_eq("rst_a", 32'(u_bus.a), 32'hDF00);
    check_eq("rst_d_out", 32'(u_bus.d_out), 32'h0);
    check_eq("rst_req_ack", 32'(req_ack), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_rx_data", 32'(rx_data), 32'h0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // both requesters at once, rr pointer 0: 0x55 first then 0xFF
    clear_logs();
    send(2'b11, 8'h55, 8'hFF, "pair");
    wait_rx(2, "pair");
    check_eq("pair_wr_count", 32'(wr_log.size()), 32'd2);
    check_eq("pair_wr0", 32'(wr_log[0]), 32'h55);
    check_eq("pair_wr1", 32'(wr_log[1]), 32'hFF);
    check_eq("pair_ack_count", 32'(ack_log.size()), 32'd2);
    check_eq("pair_ack0", 32'(ack_log[0]), 32'h1);
    check_eq("pair_ack1", 32'(ack_log[1]), 32'h2);
    check_eq("pair_rx0", 32'(rx_got[0]), 32'h55);
    check_eq("pair_rx1", 32'(rx_got[1]), 32'hFF);

    // single byte loopback from requester 0; leaves rr pointer at 1
    clear_logs();
    send(2'b01, 8'hAA, 8'h00, "single");
    wait_rx(1, "single");
    check_eq("single_wr_count", 32'(wr_log.size()), 32'd1);
    check_eq("single_wr0", 32'(wr_log[0]), 32'hAA);
    check_eq("single_ack_count", 32'(ack_log.size()), 32'd1);
    check_eq("single_ack0", 32'(ack_log[0]), 32'h1);
    check_eq("single_rx0", 32'(rx_got[0]), 32'hAA);

    // reset pulse while requester 1 is writing 0x3C
    clear_logs();
    @(posedge clk); #1;
    req_data  = {8'h3C, 8'h00};
    req_valid = 2'b10;
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      @(negedge clk);
      n++;
      found = u_bus.select && !u_bus.r_w_n;
    end
    check_eq("rstw_reached_write", 32'(found), 32'h1);
    check_eq("rstw_write_data", 32'(u_bus.d_out), 32'h3C);
    check_eq("rstw_rr_before", 32'(dut.r_rr), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstw_select", 32'(u_bus.select), 32'h0);
    check_eq("rstw_req_ack", 32'(req_ack), 32'h0);
    check_eq("rstw_state_idle", 32'(dut.r_state), 32'h0);
    check_eq("rstw_rr", 32'(dut.r_rr), 32'h0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rstw_no_ack", 32'(ack_log.size()), 32'd0);
    check_eq("rstw_no_write", 32'(wr_log.size()), 32'd0);

    // consumer stalled: first byte held, later bytes stay queued in the UART
    clear_logs();
    @(posedge clk); #1;
    rx_ready = 1'b0;
    send(2'b01, 8'h01, 8'h00, "hold1");
    send(2'b01, 8'h02, 8'h00, "hold2");
    send(2'b01, 8'h03, 8'h00, "hold3");
    repeat (60) @(negedge clk);
    check_eq("hold_rx_valid", 32'(rx_valid), 32'h1);
    check_eq("hold_rx_data", 32'(rx_data), 32'h01);
    check_eq("hold_uart_queued", 32'(rx_q.size()), 32'd2);
    check_eq("hold_wr_count", 32'(wr_log.size()), 32'd3);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    wait_rx(3, "hold");
    check_eq("hold_rx0", 32'(rx_got[0]), 32'h01);
    check_eq("hold_rx1", 32'(rx_got[1]), 32'h02);
    check_eq("hold_rx2", 32'(rx_got[2]), 32'h03);
    check_eq("hold_no_data_read_while_full", 32'(rx_rd_held), 32'd0);

    // strobe 1-of-4, rr pointer 1: requester 1 goes first
    clear_logs();
    strobe_mode = 1;
    send(2'b11, 8'h12, 8'h34, "slow");
    wait_rx(2, "slow");
    check_eq("slow_wr_count", 32'(wr_log.size()), 32'd2);
    check_eq("slow_wr0", 32'(wr_log[0]), 32'h34);
    check_eq("slow_wr1", 32'(wr_log[1]), 32'h12);
    check_eq("slow_ack0", 32'(ack_log[0]), 32'h2);
    check_eq("slow_ack1", 32'(ack_log[1]), 32'h1);
    check_eq("slow_rx0", 32'(rx_got[0]), 32'h34);
    check_eq("slow_rx1", 32'(rx_got[1]), 32'h12);
    check_eq("slow_bus_stable", 32'(stab_viol), 32'd0);
    strobe_mode = 0;

    check_eq("write_while_busy", 32'(bad_wr), 32'd0);
    check_eq("bad_bus_access", 32'(bad_addr), 32'd0);
    check_eq("timeout_pulses", 32'(to_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
